// File: rtl/bus_arb_pkg.sv
// Shared types for the serial-bus ownership arbiter and the bus top.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: init_sel_t (bus select / split-owner encoding), arb_state_t (arbiter FSM).
package bus_arb_pkg;

  // Bus select encoding; also used for split ownership (SPLIT never an owner).
  typedef enum logic [1:0] {
    NONE  = 2'b00,
    I1    = 2'b01,
    I2    = 2'b10,
    SPLIT = 2'b11
  } init_sel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    GNT_I1    = 2'b01,
    GNT_I2    = 2'b10,
    GNT_SPLIT = 2'b11
  } arb_state_t;

endpackage

// File: rtl/split_rr_arbiter.sv
// Bus-ownership arbiter: round-robin between two initiators, absolute priority for split responses.
// Latency: grant rises one cycle after the request is seen in IDLE; one idle cycle between tenures.
// Backpressure: requesters hold req high for the tenure; watchdog revokes after TIMEOUT_CYCLES.
// Ports: clk/rst (sync, active-high); req_i_1, req_i_2, req_split requests; split_ack / split_done
//        pulses from the split target; grant_i_1, grant_i_2, grant_split, sel, split_owner, timeout
//        are all registered outputs.
module split_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i_1,
  input  logic       req_i_2,
  input  logic       req_split,
  input  logic       split_ack,
  input  logic       split_done,
  output logic       grant_i_1,
  output logic       grant_i_2,
  output logic       grant_split,
  output logic [1:0] sel,
  output logic [1:0] split_owner,
  output logic       timeout
);

  localparam bit             WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state_q, state_d;
  init_sel_t        owner_q, owner_d;
  init_sel_t        sel_d;
  logic             last_i2_q, last_i2_d;  // 1: init2 won the last initiator tenure
  logic             timeout_d;
  logic [CNT_W-1:0] cnt_q;
  logic             elig_1, elig_2, elig_s, wd_hit;

  // An initiator owed a split response may not re-arbitrate until it is delivered.
  assign elig_1 = req_i_1 && (owner_q != I1);
  assign elig_2 = req_i_2 && (owner_q != I2);
  assign elig_s = req_split && (owner_q != NONE);
  assign wd_hit = WD_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_i2_d = last_i2_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (elig_s) begin
          state_d = GNT_SPLIT;
        end else if (elig_1 && elig_2) begin
          state_d   = last_i2_q ? GNT_I1 : GNT_I2;
          last_i2_d = !last_i2_q;
        end else if (elig_1) begin
          state_d   = GNT_I1;
          last_i2_d = 1'b0;
        end else if (elig_2) begin
          state_d   = GNT_I2;
          last_i2_d = 1'b1;
        end
      end
      GNT_I1: begin
        // Deferral is recorded even if the request drops in the same cycle.
        if (split_ack && (owner_q == NONE)) owner_d = I1;
        if (!req_i_1) begin
          state_d = IDLE;
        end else if (wd_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      GNT_I2: begin
        if (split_ack && (owner_q == NONE)) owner_d = I2;
        if (!req_i_2) begin
          state_d = IDLE;
        end else if (wd_hit) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      GNT_SPLIT: begin
        if (split_done) begin
          owner_d = NONE;
          state_d = IDLE;
        end else if (!req_split) begin
          state_d = IDLE;
        end else if (wd_hit) begin
          // Revoked split keeps its owner so the response can be retried.
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d = NONE;
    case (state_d)
      GNT_I1:    sel_d = I1;
      GNT_I2:    sel_d = I2;
      GNT_SPLIT: sel_d = SPLIT;
      default:   sel_d = NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= NONE;
      last_i2_q   <= 1'b1;
      cnt_q       <= '0;
      timeout     <= 1'b0;
      grant_i_1   <= 1'b0;
      grant_i_2   <= 1'b0;
      grant_split <= 1'b0;
      sel         <= NONE;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_i2_q   <= last_i2_d;
      timeout     <= timeout_d;
      grant_i_1   <= (sel_d == I1);
      grant_i_2   <= (sel_d == I2);
      grant_split <= (sel_d == SPLIT);
      sel         <= sel_d;
      // Cleared through the mandatory IDLE cycle, so it is 0 in the first grant cycle.
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign split_owner = owner_q;

endmodule

// File: doc/split_rr_arbiter.md
Name: split_rr_arbiter

Overview:
- Bus-ownership arbiter for the serial bus. It shares the single forward/return path between initiator 1, initiator 2 and the split target's response request.
- Policy: round-robin between initiators, absolute priority for split responses, a per-tenure watchdog, and split-owner bookkeeping.
- An initiator awaiting a split response is masked from re-arbitration until that response completes.
- Sits beside the address decoder in the bus top and drives the grant, select and split-owner signals.

Parameters:
- TIMEOUT_CYCLES, 256, maximum consecutive grant cycles per tenure; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT_CYCLES+1) (minimum 1), width of the tenure counter.

Ports:
- clk  in  1  bus clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_i_1  in  1  bus request from initiator port 1; held high for the whole tenure.
- req_i_2  in  1  bus request from initiator port 2.
- req_split  in  1  split target port requests the bus to return a split response.
- split_ack  in  1  split target deferred the current transaction (one-cycle pulse).
- split_done  in  1  split target ack of the final response beat (one-cycle pulse).
- grant_i_1  out  1  registered grant to initiator 1.
- grant_i_2  out  1  registered grant to initiator 2.
- grant_split  out  1  registered grant to the split target.
- sel  out  2  00 none, 01 init1, 10 init2, 11 split; registered, consistent with the grants.
- split_owner  out  2  00 none, 01 init1, 10 init2: initiator owed the pending split response.
- timeout  out  1  one-cycle pulse when a tenure is revoked by the watchdog.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst). All outputs are registered.
- Reset values: state IDLE; all grants 0; sel 00; split_owner 00; timeout 0; counter 0; last_winner = init2, so init1 wins the first tie.
- States: IDLE, GNT_I1, GNT_I2, GNT_SPLIT. Outputs decode from the state: exactly one grant is high in each GNT_* state, none in IDLE.
- Eligibility:
  - init k is eligible when req_i_k = 1 and split_owner != k.
  - split is eligible when req_split = 1 and split_owner != 00.
  - req_split with split_owner = 00 is ignored.
- IDLE priority, with the decision registered (grant rises the cycle after the request is seen in IDLE):
  1. split wins if eligible.
  2. Otherwise, if both initiators are eligible, the one that is not last_winner wins.
  3. Otherwise the single eligible initiator wins.
  4. Otherwise stay in IDLE.
- Winner update: last_winner updates on every initiator grant and is not updated on a split grant.
- GNT_Ik:
  - Holds while req_i_k = 1.
  - When req_i_k = 0 is seen, go to IDLE; the grant falls the next cycle.
  - The bus is always idle for one cycle between tenures.
- GNT_SPLIT holds while req_split = 1. It goes to IDLE on req_split = 0 or split_done = 1.
- Split bookkeeping:
  - split_ack in GNT_Ik with split_owner = 00 sets split_owner <= k. The grant continues until the initiator drops its request.
  - split_ack in IDLE or GNT_SPLIT, or while split_owner != 00, is ignored (one outstanding split only).
  - split_done in GNT_SPLIT sets split_owner <= 00. The same pulse in any other state is ignored.
- Watchdog:
  - The counter clears on entry to any GNT_* state and increments each GNT cycle.
  - When the counter = TIMEOUT_CYCLES-1 and the request is still high: go to IDLE, pulse timeout for 1 cycle coincident with the grant falling.
  - A revoked initiator is recorded as last_winner.
  - A revoked split tenure keeps split_owner unchanged.
  - The counter saturates. With TIMEOUT_CYCLES = 0 there is never a timeout.
- Simultaneous events:
  - split_ack and request drop in the same cycle: both take effect.
  - split_done and a new req_split: owner cleared, and the request is ineligible next IDLE.
- Reset mid-tenure: the next edge returns every output to its reset value, and split_owner is cleared. Requesters must re-request.

Decomposition:
- Package bus_arb_pkg:
  - init_sel_t enum (NONE=00, I1=01, I2=10, SPLIT=11), shared with the bus top.
  - arb_state_t enum.
- Single flat module with inline counter; no sub-module warranted.

Test Plan:
- Only req_i_1 rises at cycle 2 → grant_i_1=1, sel=01 from cycle 3. req_i_1 drops at cycle 6 → grant_i_1=0 at cycle 7.
- req_i_1 and req_i_2 both held continuously with 4-cycle tenures (each drops and re-raises) → grants alternate I1, I2, I1, I2 with one idle cycle between each.
- Split flow:
  - I2 granted, split_ack pulse → split_owner=10. I2 keeps req_i_2 high after releasing → I2 is not re-granted; I1 is granted if requesting.
  - req_split → grant_split=1, sel=11. split_done → split_owner=00 and I2 is eligible again.
- Contention: req_split, req_i_1 and req_i_2 all high in IDLE with split_owner=01 → grant_split wins. I2 is granted next; I1 stays masked until split_done.
- TIMEOUT_CYCLES=8, req_i_1 held forever → grant_i_1 is high exactly 8 cycles, timeout pulses once as it falls. With req_i_2 high, I2 is granted next.
- rst asserted mid-GNT_SPLIT with split_owner=01 → next cycle all grants 0, sel=00, split_owner=00, timeout=0. req_split alone is then ignored.
